// File: rtl/fetch_ifid_stage.sv
// Fetch stage and IF/ID pipeline register for the 16-bit five-stage core.
// Owns the PC, latches fetched words into IF/ID, honours decode stalls,
// applies execute redirects with a one-slot flush, stops on HALT and counts
// stall cycles with a saturating counter.
module fetch_ifid_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      imem_instr,
    input  logic             NOP_reg,
    input  logic             redirect,
    input  logic [15:0]      redirect_pc,
    output logic [15:0]      imem_addr,
    output logic             imem_en,
    output logic [15:0]      id_instr,
    output logic [15:0]      id_pc2,
    output logic             id_nop,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam logic [4:0] HALT_OPCODE = 5'b00000;

    state_t             state_q;
    logic [15:0]        pc_q;
    logic [15:0]        ifid_instr_q;
    logic [15:0]        ifid_pc2_q;
    logic               ifid_valid_q;
    logic [CNT_W-1:0]   stall_cnt_q;

    logic [15:0]        pc_plus2_d;
    logic               fetch_is_halt_d;
    logic               unused_redirect_lsb;

    // Sequential address and HALT decode of the word currently returned by imem.
    assign pc_plus2_d      = pc_q + 16'd2;
    assign fetch_is_halt_d = (imem_instr[15:11] == HALT_OPCODE);

    // Redirect targets are halfword aligned; the LSB is dropped on purpose.
    assign unused_redirect_lsb = redirect_pc[0];

    // PC, IF/ID register, run/halt state and stall counter, priority rst > redirect > stall > halt > fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= {RESET_PC[15:1], 1'b0};
            ifid_instr_q <= NOP_INSTR;
            ifid_pc2_q   <= 16'h0000;
            ifid_valid_q <= 1'b0;
            state_q      <= ST_RUN;
            stall_cnt_q  <= '0;
        end else if (redirect) begin
            pc_q         <= {redirect_pc[15:1], 1'b0};
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            state_q      <= ST_RUN;
        end else if (NOP_reg) begin
            if (stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end else if (state_q == ST_HALTED) begin
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end else begin
            ifid_instr_q <= imem_instr;
            ifid_pc2_q   <= pc_plus2_d;
            ifid_valid_q <= 1'b1;
            if (fetch_is_halt_d) begin
                state_q <= ST_HALTED;
            end else begin
                pc_q <= pc_plus2_d;
            end
        end
    end

    // Outputs come straight from state; imem_en and id_nop also see rst/NOP_reg directly.
    assign imem_addr = pc_q;
    assign imem_en   = (state_q == ST_RUN) && !rst;
    assign id_instr  = ifid_instr_q;
    assign id_pc2    = ifid_pc2_q;
    assign id_nop    = NOP_reg | ~ifid_valid_q;
    assign halted    = (state_q == ST_HALTED);
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Directed bench for fetch_ifid_stage: reset, free-run, stall, redirect,
// HALT, PC wrap, stall counter saturation and reset during a stall.
module tb_fetch_ifid_stage;

    logic        clk;
    logic        rst;
    logic [15:0] imem_instr;
    logic        NOP_reg;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] imem_addr;
    logic        imem_en;
    logic [15:0] id_instr;
    logic [15:0] id_pc2;
    logic        id_nop;
    logic        halted;
    logic [15:0] stall_cnt;

    logic        halt_en;
    logic [15:0] halt_at;

    int checks;
    int failures;

    fetch_ifid_stage #(
        .RESET_PC  (16'h0000),
        .NOP_INSTR (16'h0800),
        .CNT_W     (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_instr  (imem_instr),
        .NOP_reg     (NOP_reg),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_en     (imem_en),
        .id_instr    (id_instr),
        .id_pc2      (id_pc2),
        .id_nop      (id_nop),
        .halted      (halted),
        .stall_cnt   (stall_cnt)
    );

    // Instruction memory: 16'h4000 + address, with an optional HALT word.
    assign imem_instr = (halt_en && (imem_addr == halt_at)) ? 16'h0000 : (16'h4000 + imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL rst_addr got %h exp %h", imem_addr, 16'h0000); end
        checks++; if (id_instr !== 16'h0800) begin failures++; $display("FAIL rst_instr got %h exp %h", id_instr, 16'h0800); end
        checks++; if (id_pc2 !== 16'h0000) begin failures++; $display("FAIL rst_pc2 got %h exp %h", id_pc2, 16'h0000); end
        checks++; if (id_nop !== 1'b1) begin failures++; $display("FAIL rst_nop got %b exp 1", id_nop); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted got %b exp 0", halted); end
        checks++; if (stall_cnt !== 16'h0000) begin failures++; $display("FAIL rst_cnt got %h exp 0000", stall_cnt); end
        checks++; if (imem_en !== 1'b0) begin failures++; $display("FAIL rst_en got %b exp 0", imem_en); end
        rst = 1'b0;
        #1;
        checks++; if (imem_en !== 1'b1) begin failures++; $display("FAIL rst_release_en got %b exp 1", imem_en); end
    endtask

    task automatic test_free_run();
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++; if (imem_addr !== 16'(2 * i)) begin failures++; $display("FAIL run_addr[%0d] got %h exp %h", i, imem_addr, 16'(2 * i)); end
            checks++; if (id_instr !== 16'(16'h4000 + 2 * (i - 1))) begin failures++; $display("FAIL run_instr[%0d] got %h exp %h", i, id_instr, 16'(16'h4000 + 2 * (i - 1))); end
            checks++; if (id_pc2 !== 16'(2 * i)) begin failures++; $display("FAIL run_pc2[%0d] got %h exp %h", i, id_pc2, 16'(2 * i)); end
            checks++; if (id_nop !== 1'b0) begin failures++; $display("FAIL run_nop[%0d] got %b exp 0", i, id_nop); end
        end
    endtask

    task automatic test_stall();
        NOP_reg = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++; if (imem_addr !== 16'h0006) begin failures++; $display("FAIL stall_addr[%0d] got %h exp 0006", k, imem_addr); end
            checks++; if (id_instr !== 16'h4004) begin failures++; $display("FAIL stall_instr[%0d] got %h exp 4004", k, id_instr); end
            checks++; if (id_pc2 !== 16'h0006) begin failures++; $display("FAIL stall_pc2[%0d] got %h exp 0006", k, id_pc2); end
            checks++; if (id_nop !== 1'b1) begin failures++; $display("FAIL stall_nop[%0d] got %b exp 1", k, id_nop); end
            checks++; if (stall_cnt !== 16'(k)) begin failures++; $display("FAIL stall_cnt[%0d] got %h exp %h", k, stall_cnt, 16'(k)); end
        end
        NOP_reg = 1'b0;
        step();
        checks++; if (imem_addr !== 16'h0008) begin failures++; $display("FAIL resume_addr got %h exp 0008", imem_addr); end
        checks++; if (id_instr !== 16'h4006) begin failures++; $display("FAIL resume_instr got %h exp 4006", id_instr); end
        checks++; if (id_pc2 !== 16'h0008) begin failures++; $display("FAIL resume_pc2 got %h exp 0008", id_pc2); end
        checks++; if (id_nop !== 1'b0) begin failures++; $display("FAIL resume_nop got %b exp 0", id_nop); end
        checks++; if (stall_cnt !== 16'h0003) begin failures++; $display("FAIL resume_cnt got %h exp 0003", stall_cnt); end
    endtask

    task automatic test_redirect();
        redirect    = 1'b1;
        redirect_pc = 16'h0101;
        NOP_reg     = 1'b1;
        step();
        redirect = 1'b0;
        NOP_reg  = 1'b0;
        #1;
        checks++; if (imem_addr !== 16'h0100) begin failures++; $display("FAIL redir_addr got %h exp 0100", imem_addr); end
        checks++; if (id_instr !== 16'h0800) begin failures++; $display("FAIL redir_instr got %h exp 0800", id_instr); end
        checks++; if (id_nop !== 1'b1) begin failures++; $display("FAIL redir_nop got %b exp 1", id_nop); end
        checks++; if (stall_cnt !== 16'h0003) begin failures++; $display("FAIL redir_cnt got %h exp 0003", stall_cnt); end
        checks++; if (id_pc2 !== 16'h0008) begin failures++; $display("FAIL redir_pc2 got %h exp 0008", id_pc2); end
        step();
        checks++; if (imem_addr !== 16'h0102) begin failures++; $display("FAIL redir_next_addr got %h exp 0102", imem_addr); end
        checks++; if (id_instr !== 16'h4100) begin failures++; $display("FAIL redir_target_instr got %h exp 4100", id_instr); end
        checks++; if (id_pc2 !== 16'h0102) begin failures++; $display("FAIL redir_target_pc2 got %h exp 0102", id_pc2); end
        checks++; if (id_nop !== 1'b0) begin failures++; $display("FAIL redir_target_nop got %b exp 0", id_nop); end
    endtask

    task automatic test_halt();
        halt_en     = 1'b1;
        halt_at     = 16'h0010;
        redirect    = 1'b1;
        redirect_pc = 16'h0010;
        step();
        redirect = 1'b0;
        step();
        checks++; if (id_instr !== 16'h0000) begin failures++; $display("FAIL halt_instr got %h exp 0000", id_instr); end
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_flag got %b exp 1", halted); end
        checks++; if (imem_en !== 1'b0) begin failures++; $display("FAIL halt_en got %b exp 0", imem_en); end
        checks++; if (imem_addr !== 16'h0010) begin failures++; $display("FAIL halt_addr got %h exp 0010", imem_addr); end
        checks++; if (id_pc2 !== 16'h0012) begin failures++; $display("FAIL halt_pc2 got %h exp 0012", id_pc2); end
        for (int k = 0; k < 2; k++) begin
            step();
            checks++; if (id_instr !== 16'h0800) begin failures++; $display("FAIL halted_instr[%0d] got %h exp 0800", k, id_instr); end
            checks++; if (id_nop !== 1'b1) begin failures++; $display("FAIL halted_nop[%0d] got %b exp 1", k, id_nop); end
            checks++; if (imem_addr !== 16'h0010) begin failures++; $display("FAIL halted_addr[%0d] got %h exp 0010", k, imem_addr); end
            checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halted_flag[%0d] got %b exp 1", k, halted); end
        end
        redirect    = 1'b1;
        redirect_pc = 16'h0020;
        step();
        redirect = 1'b0;
        #1;
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL unhalt_flag got %b exp 0", halted); end
        checks++; if (imem_en !== 1'b1) begin failures++; $display("FAIL unhalt_en got %b exp 1", imem_en); end
        checks++; if (imem_addr !== 16'h0020) begin failures++; $display("FAIL unhalt_addr got %h exp 0020", imem_addr); end
        step();
        checks++; if (id_instr !== 16'h4020) begin failures++; $display("FAIL unhalt_instr got %h exp 4020", id_instr); end
        checks++; if (imem_addr !== 16'h0022) begin failures++; $display("FAIL unhalt_next_addr got %h exp 0022", imem_addr); end
        halt_en = 1'b0;
    endtask

    task automatic test_wrap();
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        step();
        redirect = 1'b0;
        step();
        checks++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL wrap_addr got %h exp 0000", imem_addr); end
        checks++; if (id_pc2 !== 16'h0000) begin failures++; $display("FAIL wrap_pc2 got %h exp 0000", id_pc2); end
        checks++; if (id_instr !== 16'h3FFE) begin failures++; $display("FAIL wrap_instr got %h exp 3ffe", id_instr); end
        step();
        checks++; if (imem_addr !== 16'h0002) begin failures++; $display("FAIL wrap_next_addr got %h exp 0002", imem_addr); end
        checks++; if (id_instr !== 16'h4000) begin failures++; $display("FAIL wrap_next_instr got %h exp 4000", id_instr); end
    endtask

    task automatic test_saturate();
        // Counter holds 3 here; 65532 more stall cycles reach 16'hFFFF.
        NOP_reg = 1'b1;
        repeat (65532) step();
        checks++; if (stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_reach got %h exp ffff", stall_cnt); end
        repeat (5) step();
        checks++; if (stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got %h exp ffff", stall_cnt); end
        checks++; if (imem_addr !== 16'h0002) begin failures++; $display("FAIL sat_addr got %h exp 0002", imem_addr); end
        checks++; if (id_instr !== 16'h4000) begin failures++; $display("FAIL sat_instr got %h exp 4000", id_instr); end
    endtask

    task automatic test_reset_mid_stall();
        rst = 1'b1;
        step();
        checks++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL mrst_addr got %h exp 0000", imem_addr); end
        checks++; if (id_instr !== 16'h0800) begin failures++; $display("FAIL mrst_instr got %h exp 0800", id_instr); end
        checks++; if (id_pc2 !== 16'h0000) begin failures++; $display("FAIL mrst_pc2 got %h exp 0000", id_pc2); end
        checks++; if (stall_cnt !== 16'h0000) begin failures++; $display("FAIL mrst_cnt got %h exp 0000", stall_cnt); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL mrst_halted got %b exp 0", halted); end
        checks++; if (imem_en !== 1'b0) begin failures++; $display("FAIL mrst_en got %b exp 0", imem_en); end
        rst     = 1'b0;
        NOP_reg = 1'b0;
        #1;
        checks++; if (id_nop !== 1'b1) begin failures++; $display("FAIL mrst_nop got %b exp 1", id_nop); end
        step();
        checks++; if (id_instr !== 16'h4000) begin failures++; $display("FAIL mrst_refetch got %h exp 4000", id_instr); end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        NOP_reg     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        halt_en     = 1'b0;
        halt_at     = 16'h0000;

        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_halt();
        test_wrap();
        test_saturate();
        test_reset_mid_stall();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_ifid_stage.md
# fetch_ifid_stage

Fetch stage and IF/ID pipeline register for the 16-bit five-stage core, directly upstream of the decode-stage stall unit. It owns the PC, addresses instruction memory, latches the fetched word into IF/ID, and honours `NOP_reg` from the stall unit by freezing PC and IF/ID while marking decode output as a bubble. It also applies control-flow redirects from execute with a one-entry flush, stops fetch on HALT, and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset
- NOP_INSTR, 16'h0800, encoding written into IF/ID on flush and reset
- CNT_W, 16, width of the stall counter

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- imem_instr  input  16  instruction word at imem_addr, valid same cycle
- NOP_reg  input  1  stall request from the decode hazard unit
- redirect  input  1  taken branch/jump resolved in execute
- redirect_pc  input  16  redirect target; bit 0 ignored
- imem_addr  output  16  equals pc_q
- imem_en  output  1  high when state is RUN and rst is low
- id_instr  output  16  IF/ID instruction register
- id_pc2  output  16  IF/ID PC+2 register
- id_nop  output  1  NOP_reg | ~ifid_valid; decode must inject a bubble into ID/EX
- halted  output  1  high in state HALTED
- stall_cnt  output  CNT_W  stall cycles since reset, saturating

## Operation
- State: pc_q[15:0] (bit 0 always 0), ifid_instr, ifid_pc2, ifid_valid, state ∈ {RUN, HALTED}, stall_cnt.
- Per-edge priority is rst > redirect > NOP_reg > HALTED > normal fetch.
- rst: pc_q←RESET_PC, ifid_instr←NOP_INSTR, ifid_pc2←0, ifid_valid←0, state←RUN, stall_cnt←0.
- redirect (either state): pc_q←{redirect_pc[15:1],0}, ifid_instr←NOP_INSTR, ifid_valid←0, state←RUN. Redirect overrides a simultaneous NOP_reg.
- NOP_reg without redirect: pc_q, ifid_* and state hold; stall_cnt increments unless all ones.
- RUN, normal: pc_q←pc_q+2 mod 2^16 (FFFE→0000), ifid_instr←imem_instr, ifid_pc2←pc_q+2, ifid_valid←1. If imem_instr[15:11]==5'b00000 (HALT), state←HALTED and pc_q holds instead of incrementing. The HALT word still enters IF/ID.
- HALTED, normal: pc_q holds, ifid_instr←NOP_INSTR, ifid_valid←0, imem_en=0. Only redirect or rst leaves HALTED. An older branch squashing HALT resumes fetch at the target.
- stall_cnt counts only NOP_reg & ~redirect cycles and never wraps.

## Timing
- Fetch-to-decode latency is 1 cycle: a word presented at imem_addr in cycle N appears on id_instr in cycle N+1.
- Redirect penalty is 1 flushed slot: the target is fetched the cycle after redirect and appears on id_instr 2 cycles after redirect. id_nop=1 for the intervening cycle.
- id_nop is combinational from NOP_reg. All other outputs are registered or derive from registered state only.
- During and after reset: imem_addr=RESET_PC, id_instr=NOP_INSTR, id_pc2=0, id_nop=1, halted=0, stall_cnt=0. imem_en=0 while rst is high.
- A stall held K cycles keeps imem_addr and id_instr constant for K edges. Fetch resumes on the first edge with NOP_reg low.
- Reset mid-stall or mid-halt takes effect on that edge and discards all state.

## Test plan
- Reset then free-run with imem returning 16'h4000+addr: imem_addr goes 0,2,4,6; id_instr lags by 1 cycle (16'h4000, 16'h4002, …); id_pc2=2,4,6; id_nop=0 from the second edge.
- NOP_reg high 3 cycles at pc_q=6: imem_addr stays 6, id_instr and id_pc2 are frozen, id_nop=1, stall_cnt increases by 3. The next edge loads address 6's word and imem_addr becomes 8.
- redirect=1 with redirect_pc=16'h0101 and NOP_reg=1 together: imem_addr=16'h0100 next cycle, id_instr=16'h0800 with id_nop=1, stall_cnt unchanged.
- HALT (16'h0000) fetched at 16'h0010: id_instr=0000 next cycle, halted=1, imem_en=0, imem_addr stays 0010. The following cycles show id_instr=0800. A later redirect to 16'h0020 clears halted and fetches 0020.
- pc_q=16'hFFFE in free-run: next imem_addr=16'h0000 and id_pc2=16'h0000.
- Preload stall_cnt near saturation by holding NOP_reg 65540 cycles: stall_cnt stops at 16'hFFFF. Then assert rst during a stall: all outputs return to reset values on that edge.
